// File: rtl/shift_left_seq.sv
// Sequential 8-bit left shifter / rotator: one bit per clock, with busy/done handshake.
// Three-state FSM (IDLE, SHIFT, DONE); result and carry are registered and held between operations.
module shift_left_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] A,
   input  logic [3:0] Shift,
   input  logic       mode,
   input  logic       start,
   output logic [7:0] result,
   output logic       carry,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] result_reg, result_next;
   logic       carry_reg, carry_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       mode_reg, mode_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         result_reg <= 8'h00;
         carry_reg  <= 1'b0;
         cnt_reg    <= 4'd0;
         mode_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         carry_reg  <= carry_next;
         cnt_reg    <= cnt_next;
         mode_reg   <= mode_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      carry_next  = carry_reg;
      cnt_next    = cnt_reg;
      mode_next   = mode_reg;
      case (state_reg)
         IDLE, DONE: begin
            // A start is honoured in DONE too, giving back-to-back operations.
            if (start) begin
               result_next = A;
               cnt_next    = Shift;
               mode_next   = mode;
               carry_next  = 1'b0;
               state_next  = (Shift != 4'd0) ? SHIFT : DONE;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            carry_next  = result_reg[7];
            result_next = {result_reg[6:0], mode_reg ? result_reg[7] : 1'b0};
            cnt_next    = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign result = result_reg;
   assign carry  = carry_reg;
   assign busy   = (state_reg == SHIFT);
   assign done   = (state_reg == DONE);

endmodule

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 Port list SHALL be fixed and ordered clock first, reset second.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 A  input  8  operand, sampled only on an accepted start.
REQ-005 Shift  input  4  left-shift count 0..15, sampled only on an accepted start.
REQ-006 mode  input  1  0 = logical left shift (zero fill); 1 = rotate left. Sampled on an accepted start.
REQ-007 start  input  1  request; accepted on a rising edge when busy=0.
REQ-008 result  output  8  registered shift result; holds its value until the next accepted start.
REQ-009 carry  output  1  registered; last bit shifted out of bit 7.
REQ-010 busy  output  1  high while shifting is in progress.
REQ-011 done  output  1  one-cycle pulse; result and carry are valid while it is high.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE. busy=1 only in SHIFT. done=1 only in DONE.
REQ-013 Accepting a start in IDLE or DONE SHALL do all of the following: result<=A, cnt<=Shift, latch mode, carry<=0; next state is SHIFT if Shift!=0, otherwise DONE.
REQ-014 Each edge in SHIFT SHALL perform one 1-bit step and then cnt<=cnt-1.
  - Logical: carry<=result[7], result<={result[6:0],1'b0}.
  - Rotate: carry<=result[7], result<={result[6:0],result[7]}.
REQ-015 When cnt reaches 0 after a step, the FSM SHALL enter DONE.
REQ-016 DONE SHALL last exactly one cycle. Without a new start it returns to IDLE. A start in DONE is accepted (back-to-back operation).
REQ-017 Latency: with the start accepted at edge k, done SHALL be high during the cycle that follows edge k+Shift. For Shift=0 that is the cycle after edge k.
REQ-018 start while busy=1 SHALL be ignored. The in-flight operation, A, Shift and mode latches SHALL be unaffected.
REQ-019 Logical shift with Shift>=8 SHALL yield result=0x00. carry = A[8-Shift] for Shift=8, otherwise 0.
REQ-020 Rotate with any Shift SHALL yield A rotated left by (Shift mod 8). carry = bit 7 of the value present before the final step.
REQ-021 Shift=0 SHALL yield result=A and carry=0.
REQ-022 result and carry SHALL NOT change in IDLE or DONE except on an accepted start.

Reset
REQ-023 rst_n low SHALL immediately force the following, independent of clk: state=IDLE, result=0x00, carry=0, busy=0, done=0, cnt=0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-025 The first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-026 A=0x96, Shift=1, mode=0, start at edge k -> busy high for 1 cycle; done pulses after edge k+1; result=0x2C, carry=1.
REQ-027 A=0x81, Shift=3, mode=1 -> done after edge k+3; result=0x0C, carry=0; busy high for exactly 3 cycles.
REQ-028 A=0xFF, Shift=0, mode=0 -> busy never high; done after edge k; result=0xFF, carry=0.
REQ-029 A=0x01, mode=0, Shift=8 -> result=0x00, carry=1. Then Shift=15 -> result=0x00, carry=0, done after edge k+15.
REQ-030 A=0x01, Shift=4, mode=0; second start (A=0xFF, Shift=1) two cycles later -> second start ignored; result=0x10, carry=0, single done pulse.
REQ-031 A=0x55, Shift=10 started; rst_n low 3 cycles later, mid-cycle -> outputs 0 immediately with no done pulse. After release, A=0x03, Shift=2, mode=0 -> result=0x0C.
